// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared widths and arbiter state encoding for the Hack RAM arbiter
package hack_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_CPU_ADDR = 2'd0,
    S_CPU_EXEC = 2'd1,
    S_VID      = 2'd2
  } arbStateT;

endpackage

// File: rtl/hack_burst_ctr.sv
// rtl/hack_burst_ctr.sv - video burst base latch, beat counter and wrapping address adder
module hack_burst_ctr
  import hack_pkg::*;
#(
  parameter int BURST_LEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] baseReg;
  logic [ADDR_W-1:0] beat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baseReg <= '0;
      beat    <= '0;
    end else if (load) begin
      baseReg <= base;
      beat    <= '0;
    end else if (advance) begin
      beat <= last ? '0 : beat + 1'b1;
    end
  end

  // Truncation to ADDR_W bits gives the top-of-RAM wrap to address 0.
  assign addr = baseReg + beat;
  assign last = (beat == ADDR_W'(BURST_LEN - 1));

endmodule

// File: rtl/hack_ram_arbiter.sv
// rtl/hack_ram_arbiter.sv - time-shares the Hack data RAM between the cpu (via clock enable)
// and a non-preemptible video burst reader
module hack_ram_arbiter
  import hack_pkg::*;
#(
  parameter int BURST_LEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ce,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_base,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  arbStateT          state;
  logic              cpuCe;
  logic              vidAck;
  logic              vidValid;
  logic              burstLoad;
  logic              burstAdvance;
  logic              burstLast;
  logic [ADDR_W-1:0] burstAddr;

  assign burstLoad    = (state == S_CPU_EXEC) && vid_req;
  assign burstAdvance = (state == S_VID);

  hack_burst_ctr #(
    .BURST_LEN(BURST_LEN)
  ) u_burst_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (burstLoad),
    .base   (vid_base),
    .advance(burstAdvance),
    .addr   (burstAddr),
    .last   (burstLast)
  );

  // cpuCe and vidAck are registered alongside the state so they drop with reset immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_CPU_ADDR;
      cpuCe    <= 1'b0;
      vidAck   <= 1'b0;
      vidValid <= 1'b0;
    end else begin
      vidValid <= vidAck;
      case (state)
        S_CPU_ADDR: begin
          state <= S_CPU_EXEC;
          cpuCe <= 1'b1;
        end
        S_CPU_EXEC: begin
          cpuCe <= 1'b0;
          if (vid_req) begin
            state  <= S_VID;
            vidAck <= 1'b1;
          end else begin
            state <= S_CPU_ADDR;
          end
        end
        S_VID: begin
          if (burstLast) begin
            state  <= S_CPU_ADDR;
            vidAck <= 1'b0;
          end
        end
        default: begin
          state  <= S_CPU_ADDR;
          cpuCe  <= 1'b0;
          vidAck <= 1'b0;
        end
      endcase
    end
  end

  // RAM read data is already one clock late, so it lines up with vidValid without a data register.
  assign ram_addr  = vidAck ? burstAddr : cpu_addr;
  assign ram_we    = cpuCe & cpu_we;
  assign ram_wdata = cpu_wdata;
  assign cpu_rdata = ram_rdata;
  assign cpu_ce    = cpuCe;
  assign vid_ack   = vidAck;
  assign vid_valid = vidValid;
  assign vid_data  = ram_rdata;

endmodule
